i2c_bus_decoder: RTL and testbench

- Synthesizable front end that watches the raw I2C wires (scl_i, sda_i) on the system clock and reduces them to bus events: START, RESTART, STOP, address bytes and data bytes, each with its ACK bit.
- Sits between the I2C pins and the transaction monitor / scoreboard. The transaction monitor consumes its byte and event strobes instead of sampling SCL/SDA with delays.
- Purely passive: it never drives SDA.

---
 rtl/i2c_types_pkg.sv | 26 ++
 rtl/i2c_line_filter.sv | 61 ++++++
 rtl/i2c_bus_decoder.sv | 175 +++++++++++++++++
 tb/tb_i2c_bus_decoder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_types_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2c_types_pkg : shared I2C types for the bus decoder and monitor  |
// | Revision      : 1.0                                               |
// +------------------------------------------------------------------+
package i2c_types_pkg;

    localparam int I2C_BITS_PER_FRAME = 9;

    typedef enum logic {
        I2_WRITE = 1'b0,
        I2_READ  = 1'b1
    } i2c_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } dec_state_t;

    function automatic i2c_op_t rw_to_op(input logic rw);
        return rw ? I2_READ : I2_WRITE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2c_line_filter : synchronizer + glitch filter for one I2C line   |
// | Revision        : 1.0                                             |
// +------------------------------------------------------------------+
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [3:0] c_CNT_MAX = 4'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   prev_q;
    logic                   w_sample;

    assign w_sample = sync_q[SYNC_STAGES-1];

    // The level only flips once FILTER_LEN disagreeing samples have been seen in a row.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], line_i};
        level_d = level_q;
        cnt_d   = '0;
        if (w_sample != level_q) begin
            if (cnt_q >= c_CNT_MAX) begin
                level_d = w_sample;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~prev_q;
    assign fall_o  = ~level_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/i2c_bus_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2c_bus_decoder : passive SCL/SDA decoder into bus event strobes  |
// | Revision        : 1.0                                             |
// +------------------------------------------------------------------+
module i2c_bus_decoder
    import i2c_types_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 3,
    parameter int I2C_DATA_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      start_o,
    output logic                      restart_o,
    output logic                      stop_o,
    output logic                      byte_valid_o,
    output logic [I2C_DATA_WIDTH-1:0] byte_o,
    output logic                      ack_o,
    output logic                      addr_phase_o,
    output logic [6:0]                addr_o,
    output logic                      rw_o,
    output logic                      busy_o,
    output logic                      trunc_err_o
);

    localparam int         c_FRAME_W  = I2C_DATA_WIDTH + 1;
    localparam logic [3:0] c_LAST_BIT = 4'(I2C_BITS_PER_FRAME - 1);

    logic w_scl_f, w_scl_rise, w_scl_fall;
    logic w_sda_f, w_sda_rise, w_sda_fall;
    logic w_start, w_stop, w_sda_edge;
    logic [c_FRAME_W-1:0] w_frame;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk_i(clk_i), .rst_i(rst_i), .line_i(scl_i),
        .level_o(w_scl_f), .rise_o(w_scl_rise), .fall_o(w_scl_fall)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk_i(clk_i), .rst_i(rst_i), .line_i(sda_i),
        .level_o(w_sda_f), .rise_o(w_sda_rise), .fall_o(w_sda_fall)
    );

    // SCL high in both this and the previous cycle, so coincident edges never qualify.
    assign w_start    = w_scl_f & ~w_scl_rise & w_sda_fall;
    assign w_stop     = w_scl_f & ~w_scl_rise & w_sda_rise;
    assign w_sda_edge = w_sda_rise | w_sda_fall;

    dec_state_t                state_q, state_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [I2C_DATA_WIDTH-1:0] sr_q, sr_d;
    logic                      smp_q, smp_d, pend_q, pend_d;
    logic                      start_q, start_d, restart_q, restart_d, stop_q, stop_d;
    logic                      valid_q, valid_d, trunc_q, trunc_d, busy_q, busy_d;
    logic [I2C_DATA_WIDTH-1:0] byte_q, byte_d;
    logic                      ack_q, ack_d, aph_q, aph_d, rw_q, rw_d;
    logic [6:0]                addr_q, addr_d;

    assign w_frame = {sr_q, smp_q};

    // SDA is sampled on the SCL rise but the bit is only committed on the following fall,
    // so the SCL rise that precedes a STOP or RESTART never counts as a data bit.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        smp_d     = smp_q;
        pend_d    = pend_q;
        busy_d    = busy_q;
        byte_d    = byte_q;
        ack_d     = ack_q;
        aph_d     = aph_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        start_d   = 1'b0;
        restart_d = 1'b0;
        stop_d    = 1'b0;
        valid_d   = 1'b0;
        trunc_d   = 1'b0;
        if (w_stop) begin
            stop_d    = 1'b1;
            trunc_d   = (bit_cnt_q != 4'd0);
            state_d   = IDLE;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
            pend_d    = 1'b0;
        end else if (w_start) begin
            start_d   = ~busy_q;
            restart_d = busy_q;
            trunc_d   = (bit_cnt_q != 4'd0);
            state_d   = ADDR;
            busy_d    = 1'b1;
            bit_cnt_d = '0;
            pend_d    = 1'b0;
        end else if (state_q != IDLE) begin
            if (w_scl_rise && !w_sda_edge) begin
                smp_d  = w_sda_f;
                pend_d = 1'b1;
            end else if (w_scl_fall && pend_q) begin
                pend_d = 1'b0;
                sr_d   = w_frame[I2C_DATA_WIDTH-1:0];
                if (bit_cnt_q == c_LAST_BIT) begin
                    bit_cnt_d = '0;
                    valid_d   = 1'b1;
                    byte_d    = w_frame[c_FRAME_W-1:1];
                    ack_d     = w_frame[0];
                    aph_d     = (state_q == ADDR);
                    if (state_q == ADDR) begin
                        addr_d  = w_frame[c_FRAME_W-1:2];
                        rw_d    = w_frame[1];
                        state_d = DATA;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            smp_q     <= 1'b0;
            pend_q    <= 1'b0;
            busy_q    <= 1'b0;
            byte_q    <= '0;
            ack_q     <= 1'b0;
            aph_q     <= 1'b0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            start_q   <= 1'b0;
            restart_q <= 1'b0;
            stop_q    <= 1'b0;
            valid_q   <= 1'b0;
            trunc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            smp_q     <= smp_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            byte_q    <= byte_d;
            ack_q     <= ack_d;
            aph_q     <= aph_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            start_q   <= start_d;
            restart_q <= restart_d;
            stop_q    <= stop_d;
            valid_q   <= valid_d;
            trunc_q   <= trunc_d;
        end
    end

    assign start_o      = start_q;
    assign restart_o    = restart_q;
    assign stop_o       = stop_q;
    assign byte_valid_o = valid_q;
    assign byte_o       = byte_q;
    assign ack_o        = ack_q;
    assign addr_phase_o = aph_q;
    assign addr_o       = addr_q;
    assign rw_o         = rw_q;
    assign busy_o       = busy_q;
    assign trunc_err_o  = trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_i2c_bus_decoder : directed + random bench for i2c_bus_decoder  |
// | Revision           : 1.0                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_i2c_bus_decoder;
    import i2c_types_pkg::*;

    localparam int Q        = 10;
    localparam int EV_START = 1;
    localparam int EV_RST   = 2;
    localparam int EV_STOP  = 3;
    localparam int EV_BYTE  = 4;
    localparam int EV_TRUNC = 5;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       scl_i = 1'b1;
    logic       sda_i = 1'b1;
    logic       start_o, restart_o, stop_o, byte_valid_o, ack_o, addr_phase_o;
    logic       rw_o, busy_o, trunc_err_o;
    logic [7:0] byte_o;
    logic [6:0] addr_o;

    always #5 clk_i = ~clk_i;

    i2c_bus_decoder u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .scl_i(scl_i), .sda_i(sda_i),
        .start_o(start_o), .restart_o(restart_o), .stop_o(stop_o),
        .byte_valid_o(byte_valid_o), .byte_o(byte_o), .ack_o(ack_o),
        .addr_phase_o(addr_phase_o), .addr_o(addr_o), .rw_o(rw_o),
        .busy_o(busy_o), .trunc_err_o(trunc_err_o)
    );

    typedef struct {
        int         kind;
        logic [7:0] b;
        logic       ack;
        logic       aph;
        logic [6:0] addr;
        logic       rw;
        int         cyc;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  cyc_cnt  = 0;
    int  n_assert = 0;
    int  n_fail   = 0;

    // Reference model state: transaction-level view of the bus
    logic       m_busy  = 1'b0;
    logic       m_first = 1'b0;
    int         m_bits  = 0;
    logic [6:0] m_addr  = '0;
    logic       m_rw    = 1'b0;

    function automatic ev_t mk_obs(input int k);
        ev_t e;
        e.kind = k; e.b = byte_o; e.ack = ack_o; e.aph = addr_phase_o;
        e.addr = addr_o; e.rw = rw_o; e.cyc = cyc_cnt;
        return e;
    endfunction

    always @(negedge clk_i) begin
        cyc_cnt++;
        if (trunc_err_o)  obs_q.push_back(mk_obs(EV_TRUNC));
        if (start_o)      obs_q.push_back(mk_obs(EV_START));
        if (restart_o)    obs_q.push_back(mk_obs(EV_RST));
        if (stop_o)       obs_q.push_back(mk_obs(EV_STOP));
        if (byte_valid_o) obs_q.push_back(mk_obs(EV_BYTE));
    end

    task automatic exp_push(input int k, input logic [7:0] b, input logic ack, input logic aph);
        ev_t e;
        e.kind = k; e.b = b; e.ack = ack; e.aph = aph;
        e.addr = m_addr; e.rw = m_rw; e.cyc = 0;
        exp_q.push_back(e);
    endtask

    task automatic m_start();
        if (m_bits != 0) exp_push(EV_TRUNC, 8'h0, 1'b0, 1'b0);
        exp_push(m_busy ? EV_RST : EV_START, 8'h0, 1'b0, 1'b0);
        m_busy = 1'b1; m_first = 1'b1; m_bits = 0;
    endtask

    task automatic m_stop();
        if (m_bits != 0) exp_push(EV_TRUNC, 8'h0, 1'b0, 1'b0);
        exp_push(EV_STOP, 8'h0, 1'b0, 1'b0);
        m_busy = 1'b0; m_first = 1'b0; m_bits = 0;
    endtask

    task automatic m_byte(input logic [7:0] b, input logic ack);
        if (m_first) begin
            m_addr = b[7:1];
            m_rw   = b[0];
        end
        exp_push(EV_BYTE, b, ack, m_first);
        m_first = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic drv_bit(input logic b);
        sda_i = b;    wait_cyc(Q);
        scl_i = 1'b1; wait_cyc(2 * Q);
        scl_i = 1'b0; wait_cyc(Q);
    endtask

    task automatic do_start();
        if (scl_i == 1'b0) begin
            sda_i = 1'b1; wait_cyc(Q);
            scl_i = 1'b1; wait_cyc(Q);
        end else begin
            sda_i = 1'b1; wait_cyc(Q);
        end
        sda_i = 1'b0; wait_cyc(Q);
        scl_i = 1'b0; wait_cyc(Q);
        m_start();
    endtask

    task automatic do_stop();
        sda_i = 1'b0; wait_cyc(Q);
        scl_i = 1'b1; wait_cyc(Q);
        sda_i = 1'b1; wait_cyc(2 * Q);
        m_stop();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) drv_bit(b[i]);
        m_bits += n;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) drv_bit(b[i]);
        drv_bit(ack);
        m_byte(b, ack);
    endtask

    task automatic check_events(input string tag);
        n_assert++;
        assert (obs_q.size() == exp_q.size()) else begin
            n_fail++;
            $error("FAIL %s event count: observed %0d expected %0d", tag, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_assert++;
            assert (obs_q[i].kind === exp_q[i].kind) else begin
                n_fail++;
                $error("FAIL %s event[%0d] kind: observed %0d expected %0d", tag, i, obs_q[i].kind, exp_q[i].kind);
            end
            if (exp_q[i].kind == EV_BYTE && obs_q[i].kind == EV_BYTE) begin
                n_assert++;
                assert ({obs_q[i].b, obs_q[i].ack, obs_q[i].aph, obs_q[i].addr, obs_q[i].rw} ===
                        {exp_q[i].b, exp_q[i].ack, exp_q[i].aph, exp_q[i].addr, exp_q[i].rw}) else begin
                    n_fail++;
                    $error("FAIL %s byte[%0d]: observed b=%h ack=%b aph=%b addr=%h rw=%b expected b=%h ack=%b aph=%b addr=%h rw=%b",
                           tag, i, obs_q[i].b, obs_q[i].ack, obs_q[i].aph, obs_q[i].addr, obs_q[i].rw,
                           exp_q[i].b, exp_q[i].ack, exp_q[i].aph, exp_q[i].addr, exp_q[i].rw);
                end
            end
            if (exp_q[i].kind == EV_TRUNC && i + 1 < obs_q.size()) begin
                n_assert++;
                assert (obs_q[i].cyc == obs_q[i+1].cyc) else begin
                    n_fail++;
                    $error("FAIL %s trunc alignment: observed cycle %0d vs condition cycle %0d, expected equal",
                           tag, obs_q[i].cyc, obs_q[i+1].cyc);
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [23:0] v;
        v = {start_o, restart_o, stop_o, byte_valid_o, byte_o, ack_o, addr_phase_o, addr_o, rw_o, busy_o, trunc_err_o};
        n_assert++;
        assert (v === 24'h0) else begin
            n_fail++;
            $error("FAIL %s outputs: observed %h expected %h", tag, v, 24'h0);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    logic       busy_seen;
    logic [6:0] ra;
    logic [7:0] rd;
    int         nb;

    initial begin
        // 1: reset and an idle bus
        #2 rst_i = 1'b0;
        wait_cyc(4);
        check_reset_outputs("reset_values");
        rst_i = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_i);
            busy_seen = busy_seen | busy_o;
        end
        check_bit("idle_busy", busy_seen, 1'b0);
        check_events("idle");

        // 2: write 0x22, data 0xA5
        do_start();
        send_byte(8'h44, 1'b0);
        check_bit("busy_in_txn", busy_o, 1'b1);
        send_byte(8'hA5, 1'b0);
        do_stop();
        check_bit("busy_after_stop", busy_o, 1'b0);
        check_events("write_22");

        // 3: write then repeated-start read with NACK
        do_start();
        send_byte(8'h44, 1'b0);
        send_byte(8'h01, 1'b0);
        do_start();
        send_byte(8'h45, 1'b0);
        send_byte(8'h7E, 1'b1);
        check_bit("rw_read", rw_o, 1'b1);
        n_assert++;
        assert (rw_to_op(rw_o) === I2_READ) else begin
            n_fail++;
            $error("FAIL rw_op: observed %0d expected %0d", rw_to_op(rw_o), I2_READ);
        end
        do_stop();
        check_events("restart_read");

        // 4: glitches shorter than the filter, then a pulse exactly FILTER_LEN wide
        wait_cyc(20);
        sda_i = 1'b0; wait_cyc(2); sda_i = 1'b1; wait_cyc(30);
        scl_i = 1'b0; wait_cyc(2); scl_i = 1'b1; wait_cyc(30);
        check_events("glitch_2cyc");
        sda_i = 1'b0; wait_cyc(3); sda_i = 1'b1; wait_cyc(30);
        m_start();
        m_stop();
        check_events("pulse_3cyc");

        // 5: STOP after four data bits
        do_start();
        send_byte(8'h44, 1'b0);
        send_bits(8'hB0, 4);
        do_stop();
        check_events("trunc_stop");
        do_start();
        send_byte(8'h5A, 1'b0);
        send_byte(8'hC3, 1'b1);
        do_stop();
        check_events("after_trunc");

        // 6: asynchronous reset mid-byte
        do_start();
        send_bits(8'h44, 4);
        @(posedge clk_i);
        #2 rst_i = 1'b0;
        #1 check_reset_outputs("async_reset");
        m_busy = 1'b0; m_first = 1'b0; m_bits = 0;
        scl_i = 1'b1; sda_i = 1'b1;
        wait_cyc(5);
        rst_i = 1'b1;
        wait_cyc(20);
        check_events("reset_mid_byte");
        do_start();
        send_byte(8'h44, 1'b0);
        do_stop();
        check_events("after_reset");

        // 7: random transfers, some with a repeated start
        for (int t = 0; t < 6; t++) begin
            ra = 7'($urandom_range(0, 127));
            nb = $urandom_range(1, 3);
            do_start();
            send_byte({ra, 1'($urandom_range(0, 1))}, 1'b0);
            for (int k = 0; k < nb; k++) begin
                rd = 8'($urandom_range(0, 255));
                send_byte(rd, 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 1) == 1) begin
                do_start();
                send_byte({ra, 1'b1}, 1'b0);
                rd = 8'($urandom_range(0, 255));
                send_byte(rd, 1'b1);
            end
            do_stop();
            check_events("random_txn");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
